// File: rtl/decoder_scan_pkg.sv
// Package for the decoder scan sequencer.
// Contents: FSM state encoding, the 74138-style enable codes, and a helper that
// sizes the dwell/blank counters from their cycle counts.
package decoder_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  // {G, GA, GB}: the decoder is enabled only for G=1, GA=0, GB=0.
  localparam logic [2:0] DEC_ON  = 3'b100;
  localparam logic [2:0] DEC_OFF = 3'b011;

  // Bits needed to hold 0..max_val. Never returns less than one bit, so a zero
  // blank count still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/scan_next_ch.sv
// Combinational channel picker for the decoder scan sequencer.
// Ports:
//   cur        in  3  channel currently addressed
//   num_ch     in  3  index of the last channel in the frame
//   mask       in  8  per-channel enable (all ones when masking is not built)
//   first      out 3  lowest enabled channel in 0..num_ch
//   next       out 3  lowest enabled channel above cur, or first on wrap
//   wrap       out 1  no enabled channel above cur; the frame is complete
//   none_valid out 1  no channel in 0..num_ch is enabled
module scan_next_ch (
  input  logic [2:0] cur,
  input  logic [2:0] num_ch,
  input  logic [7:0] mask,
  output logic [2:0] first,
  output logic [2:0] next,
  output logic       wrap,
  output logic       none_valid
);

  logic [7:0] valid;
  logic       found;

  always_comb begin
    valid = '0;
    first = '0;
    next  = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid[i] = mask[i] && (3'(i) <= num_ch);
    end
    none_valid = (valid == 8'd0);
    // Walk downwards so the lowest qualifying index is the last one written.
    for (int i = 7; i >= 0; i--) begin
      if (valid[i]) first = 3'(i);
    end
    for (int i = 7; i >= 0; i--) begin
      if (valid[i] && (3'(i) > cur)) begin
        next  = 3'(i);
        found = 1'b1;
      end
    end
    // A current address above a freshly lowered num_ch also lands here.
    wrap = !found;
    if (!found) next = first;
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer driving a 74138-style 3-to-8 decoder. Walks the address A
// through channels 0..num_ch, enabling the decoder for DWELL_CYC cycles per
// channel with a BLANK_CYC-cycle disabled gap between channels, so the address
// always settles before the enables come on (no ghosting).
// Optional feature macro: SCAN_MASK_EN adds ch_mask and skips masked-out channels.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   en                  level: 1 = scan, 0 = return to IDLE on the next edge
//   hold                level: 1 = stay on the current channel once its dwell ends
//   num_ch[2:0]         last channel of the frame, sampled only when advancing
//   ch_mask[7:0]        per-channel enable (SCAN_MASK_EN builds only)
//   G, GA, GB, A[2:0]   registered decoder enables and address
//   frame_done          one-cycle pulse on the edge that wraps back to the first channel
//   busy                registered, high while the FSM is not IDLE
//   dbg_state[1:0]      current FSM state for observation
// There is no handshake: en and hold are plain levels sampled on every edge.
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_CYC = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       hold,
  input  logic [2:0] num_ch,
`ifdef SCAN_MASK_EN
  input  logic [7:0] ch_mask,
`endif
  output logic       G,
  output logic       GA,
  output logic       GB,
  output logic [2:0] A,
  output logic       frame_done,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int DW_W = cnt_width(DWELL_CYC);
  localparam int BL_W = cnt_width(BLANK_CYC);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYC - 1);
  localparam logic [BL_W-1:0] BLANK_LAST = BL_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  // State entered after choosing a channel: a zero-length gap goes straight to DRIVE.
  localparam scan_state_t POST_PICK = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

  scan_state_t     state, nxt_state;
  logic [2:0]      a_q, nxt_a;
  logic [2:0]      dec_q;
  logic            frame_q, nxt_frame;
  logic            busy_q;
  logic [DW_W-1:0] dwell_cnt, nxt_dwell;
  logic [BL_W-1:0] blank_cnt, nxt_blank;

  logic [7:0] mask;
  logic [2:0] first_ch, next_ch;
  logic       wrap, none_valid;

`ifdef SCAN_MASK_EN
  assign mask = ch_mask;
`else
  assign mask = 8'hFF;
`endif

  scan_next_ch u_next (
    .cur        (a_q),
    .num_ch     (num_ch),
    .mask       (mask),
    .first      (first_ch),
    .next       (next_ch),
    .wrap       (wrap),
    .none_valid (none_valid)
  );

  always_comb begin
    nxt_state = state;
    nxt_a     = a_q;
    nxt_frame = 1'b0;
    nxt_dwell = dwell_cnt;
    nxt_blank = blank_cnt;
    if (!en) begin
      nxt_state = ST_IDLE;
      nxt_a     = '0;
      nxt_dwell = '0;
      nxt_blank = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          nxt_a     = '0;
          nxt_dwell = '0;
          nxt_blank = '0;
          // With nothing enabled this keeps re-evaluating every cycle.
          if (!none_valid) begin
            nxt_a     = first_ch;
            nxt_state = POST_PICK;
          end
        end
        ST_BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            nxt_state = ST_DRIVE;
            nxt_blank = '0;
            nxt_dwell = '0;
          end else begin
            nxt_blank = blank_cnt + BL_W'(1);
          end
        end
        ST_DRIVE: begin
          if (dwell_cnt != DWELL_LAST) begin
            nxt_dwell = dwell_cnt + DW_W'(1);
          end else if (!hold) begin
            // Dwell expired and not frozen: pick the next channel.
            nxt_dwell = '0;
            nxt_blank = '0;
            if (none_valid) begin
              nxt_state = ST_IDLE;
              nxt_a     = '0;
            end else begin
              nxt_state = POST_PICK;
              nxt_a     = next_ch;
              nxt_frame = wrap;
            end
          end
        end
        default: begin
          nxt_state = ST_IDLE;
          nxt_a     = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      dec_q     <= DEC_OFF;
      frame_q   <= 1'b0;
      busy_q    <= 1'b0;
      dwell_cnt <= '0;
      blank_cnt <= '0;
    end else begin
      state     <= nxt_state;
      a_q       <= nxt_a;
      dec_q     <= (nxt_state == ST_DRIVE) ? DEC_ON : DEC_OFF;
      frame_q   <= nxt_frame;
      busy_q    <= (nxt_state != ST_IDLE);
      dwell_cnt <= nxt_dwell;
      blank_cnt <= nxt_blank;
    end
  end

  assign {G, GA, GB} = dec_q;
  assign A           = a_q;
  assign frame_done  = frame_q;
  assign busy        = busy_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl with DWELL_CYC=3, BLANK_CYC=1.
// Observed vector per cycle: {G, GA, GB, A[2:0], frame_done, busy}.
module tb_decoder_scan_ctrl;

  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       hold;
  logic [2:0] num_ch;
`ifdef SCAN_MASK_EN
  logic [7:0] ch_mask;
`endif
  logic       G, GA, GB;
  logic [2:0] A;
  logic       frame_done;
  logic       busy;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  typedef struct {
    logic         en;
    logic [2:0]   num_ch;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  decoder_scan_ctrl #(.DWELL_CYC(3), .BLANK_CYC(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .hold       (hold),
    .num_ch     (num_ch),
`ifdef SCAN_MASK_EN
    .ch_mask    (ch_mask),
`endif
    .G          (G),
    .GA         (GA),
    .GB         (GB),
    .A          (A),
    .frame_done (frame_done),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- expected-value helper ----------------
  function automatic logic [W-1:0] mk(input bit on, input int a, input bit fd, input bit bsy);
    logic [2:0] dec;
    dec = on ? 3'b100 : 3'b011;
    return {dec, 3'(a), fd, bsy};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name);
    logic [W-1:0] exp, act;
    act = {G, GA, GB, A, frame_done, busy};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued, got %b", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got {dec,A,fd,busy}=%b expected %b", name, act, exp);
      end
    end
  endtask

  // Queue the expectation, let one rising edge pass, compare at the falling edge.
  task automatic cycle(input string name, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    check(name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drop_en();
    en   = 1'b0;
    hold = 1'b0;
    cycle("en_low_idle", mk(0, 0, 0, 0));
  endtask

  // From IDLE with every channel enabled: each channel takes 4 cycles
  // (1 blank + 3 on); frame_done rides the blank cycle of channel 0 after a wrap.
  task automatic run_scan(input int n, input int cycles);
    int p, c;
    num_ch = 3'(n);
    for (int t = 1; t <= cycles; t++) begin
      en   = 1'b1;
      hold = 1'b0;
      p = (t - 1) % 4;
      c = ((t - 1) / 4) % (n + 1);
      cycle("scan", mk(p != 0, c, (p == 0) && (c == 0) && (t > 1), 1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    hold     = 1'b0;
    num_ch   = 3'd7;
`ifdef SCAN_MASK_EN
    ch_mask  = 8'hFF;
`endif

    vecs[0] = '{en: 1'b0, num_ch: 3'd7, exp: mk(0, 0, 0, 0)};
    vecs[1] = '{en: 1'b1, num_ch: 3'd7, exp: mk(0, 0, 0, 1)};
    vecs[2] = '{en: 1'b1, num_ch: 3'd7, exp: mk(1, 0, 0, 1)};
    vecs[3] = '{en: 1'b1, num_ch: 3'd7, exp: mk(1, 0, 0, 1)};
    vecs[4] = '{en: 1'b1, num_ch: 3'd7, exp: mk(1, 0, 0, 1)};
    vecs[5] = '{en: 1'b1, num_ch: 3'd7, exp: mk(0, 1, 0, 1)};
    vecs[6] = '{en: 1'b0, num_ch: 3'd7, exp: mk(0, 0, 0, 0)};

    #12;
    exp_q.push_back(mk(0, 0, 0, 0));
    check("reset_values");
    @(negedge clk);
    rst_n = 1'b1;

    // Startup latency, first dwell, and en low during BLANK.
    for (int i = 0; i < 7; i++) begin
      en     = vecs[i].en;
      num_ch = vecs[i].num_ch;
      cycle("vec_table", vecs[i].exp);
    end

    // Two full frames over all eight channels.
    run_scan(7, 64);

    // en low mid-DRIVE at A=5, then restart from channel 0.
    drop_en();
    run_scan(7, 22);
    drop_en();
    en = 1'b1;
    cycle("restart_a0", mk(0, 0, 0, 1));
    drop_en();

    // Three-channel frame.
    run_scan(2, 40);
    drop_en();

    // Hold on channel 3 well past its dwell, then release.
    run_scan(7, 14);
    hold = 1'b1;
    for (int i = 0; i < 12; i++) cycle("hold_a3", mk(1, 3, 0, 1));
    hold = 1'b0;
    cycle("hold_release_blank", mk(0, 4, 0, 1));
    for (int i = 0; i < 3; i++) cycle("after_hold_a4", mk(1, 4, 0, 1));
    cycle("after_hold_a5", mk(0, 5, 0, 1));
    drop_en();

    // num_ch lowered below the current address wraps at the next advance.
    run_scan(7, 22);
    num_ch = 3'd2;
    cycle("lowered_a5", mk(1, 5, 0, 1));
    cycle("lowered_a5", mk(1, 5, 0, 1));
    cycle("lowered_wrap", mk(0, 0, 1, 1));
    for (int i = 0; i < 3; i++) cycle("lowered_a0", mk(1, 0, 0, 1));
    cycle("lowered_a1", mk(0, 1, 0, 1));
    drop_en();

    // Asynchronous reset in the middle of a BLANK cycle.
    run_scan(7, 5);
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_reset_blank", mk(0, 0, 0, 1));
    cycle("post_reset_on", mk(1, 0, 0, 1));
    drop_en();

`ifdef SCAN_MASK_EN
    // Channels 2, 5, 7 only; then an empty mask sends the scan to IDLE.
    ch_mask = 8'b1010_0100;
    num_ch  = 3'd7;
    en      = 1'b1;
    cycle("mask_blank_a2", mk(0, 2, 0, 1));
    for (int i = 0; i < 3; i++) cycle("mask_a2", mk(1, 2, 0, 1));
    cycle("mask_blank_a5", mk(0, 5, 0, 1));
    for (int i = 0; i < 3; i++) cycle("mask_a5", mk(1, 5, 0, 1));
    cycle("mask_blank_a7", mk(0, 7, 0, 1));
    for (int i = 0; i < 3; i++) cycle("mask_a7", mk(1, 7, 0, 1));
    cycle("mask_wrap_a2", mk(0, 2, 1, 1));
    cycle("mask_a2_again", mk(1, 2, 0, 1));
    ch_mask = 8'h00;
    cycle("mask_pending", mk(1, 2, 0, 1));
    cycle("mask_pending", mk(1, 2, 0, 1));
    for (int i = 0; i < 4; i++) cycle("mask_empty_idle", mk(0, 0, 0, 0));
    ch_mask = 8'h10;
    cycle("mask_resume_a4", mk(0, 4, 0, 1));
    drop_en();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
